// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, state encoding,
// IR field positions and the instruction class enum.
package seq_pkg;

   localparam int OPC_W = 5;
   localparam int REG_W = 4;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   localparam int IR_OPC_LSB = 27;
   localparam int IR_RA_LSB  = 23;
   localparam int IR_RB_LSB  = 19;
   localparam int IR_RC_LSB  = 15;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_T0     = 4'd1,
      S_T1     = 4'd2,
      S_T2     = 4'd3,
      S_T3     = 4'd4,
      S_T4     = 4'd5,
      S_T5     = 4'd6,
      S_T6     = 4'd7,
      S_HALTED = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } instr_class_e;

endpackage

// File: rtl/seq_ir_decode.sv
// Combinational IR decode: splits out the opcode and register fields and
// classifies the instruction for the sequencer FSM.
module seq_ir_decode
   import seq_pkg::*;
(
   input  logic [31:0]      ir,
   output instr_class_e     cls,
   output logic [OPC_W-1:0] opcode,
   output logic [REG_W-1:0] ra,
   output logic [REG_W-1:0] rb,
   output logic [REG_W-1:0] rc
);

   logic [IR_RC_LSB-1:0] unused_ir_low;
   assign unused_ir_low = ir[IR_RC_LSB-1:0];

   assign opcode = ir[IR_OPC_LSB +: OPC_W];
   assign ra     = ir[IR_RA_LSB  +: REG_W];
   assign rb     = ir[IR_RB_LSB  +: REG_W];
   assign rc     = ir[IR_RC_LSB  +: REG_W];

   always_comb begin
      cls = CLS_ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_RTYPE;
         OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                  cls = CLS_UNARY;
         OP_NOP:                          cls = CLS_NOP;
         OP_HALT:                         cls = CLS_HALT;
         default:                         cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Hardwired fetch/execute control unit for the single-bus datapath.
// Define SEQ_MEM_WAIT_EN to make T1 wait for mem_ready; otherwise T1 is one cycle.
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int RIDX = 4
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            run,
   input  logic            mem_ready,
   input  logic [31:0]     ir,
   output logic            PCout,
   output logic            PCin,
   output logic            IncPC,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic            Zin,
   output logic            ZLOout,
   output logic            ZHIout,
   output logic            HIin,
   output logic            LOin,
   output logic            read,
   output logic            gp_out_en,
   output logic [RIDX-1:0] gp_out_idx,
   output logic            gp_in_en,
   output logic [RIDX-1:0] gp_in_idx,
   output logic [OPW-1:0]  operation,
   output logic [3:0]      state,
   output logic            instr_done,
   output logic            halted,
   output logic            illegal
);

   state_e           state_q, state_d;
   instr_class_e     cls;
   logic [OPC_W-1:0] opcode;
   logic [REG_W-1:0] ra, rb, rc;

   seq_ir_decode u_decode (
      .ir     (ir),
      .cls    (cls),
      .opcode (opcode),
      .ra     (ra),
      .rb     (rb),
      .rc     (rc)
   );

`ifndef SEQ_MEM_WAIT_EN
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   always_ff @(posedge clock) begin
      if (clear) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d    = state_q;
      PCout      = 1'b0;
      PCin       = 1'b0;
      IncPC      = 1'b0;
      MARin      = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      Zin        = 1'b0;
      ZLOout     = 1'b0;
      ZHIout     = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      read       = 1'b0;
      gp_out_en  = 1'b0;
      gp_out_idx = '0;
      gp_in_en   = 1'b0;
      gp_in_idx  = '0;
      operation  = '0;
      instr_done = 1'b0;
      halted     = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            Zin     = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            ZLOout = 1'b1;
            PCin   = 1'b1;
            read   = 1'b1;
            MDRin  = 1'b1;
`ifdef SEQ_MEM_WAIT_EN
            if (mem_ready) state_d = S_T2;
`else
            state_d = S_T2;
`endif
         end
         S_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            case (cls)
               CLS_RTYPE: begin
                  gp_out_en  = 1'b1;
                  gp_out_idx = RIDX'(rb);
                  Yin        = 1'b1;
                  state_d    = S_T4;
               end
               CLS_MULDIV: begin
                  gp_out_en  = 1'b1;
                  gp_out_idx = RIDX'(ra);
                  Yin        = 1'b1;
                  state_d    = S_T4;
               end
               CLS_UNARY: begin
                  gp_out_en  = 1'b1;
                  gp_out_idx = RIDX'(rb);
                  operation  = OPW'(opcode);
                  Zin        = 1'b1;
                  state_d    = S_T4;
               end
               CLS_NOP: instr_done = 1'b1;
               CLS_HALT: begin
                  instr_done = 1'b1;
                  state_d    = S_HALTED;
               end
               default: begin
                  instr_done = 1'b1;
                  illegal    = 1'b1;
               end
            endcase
         end
         S_T4: begin
            case (cls)
               CLS_RTYPE: begin
                  gp_out_en  = 1'b1;
                  gp_out_idx = RIDX'(rc);
                  operation  = OPW'(opcode);
                  Zin        = 1'b1;
                  state_d    = S_T5;
               end
               CLS_MULDIV: begin
                  gp_out_en  = 1'b1;
                  gp_out_idx = RIDX'(rb);
                  operation  = OPW'(opcode);
                  Zin        = 1'b1;
                  state_d    = S_T5;
               end
               CLS_UNARY: begin
                  ZLOout     = 1'b1;
                  gp_in_en   = 1'b1;
                  gp_in_idx  = RIDX'(ra);
                  instr_done = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_T5: begin
            case (cls)
               CLS_RTYPE: begin
                  ZLOout     = 1'b1;
                  gp_in_en   = 1'b1;
                  gp_in_idx  = RIDX'(ra);
                  instr_done = 1'b1;
               end
               CLS_MULDIV: begin
                  ZLOout  = 1'b1;
                  LOin    = 1'b1;
                  state_d = S_T6;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_T6: begin
            if (cls == CLS_MULDIV) begin
               ZHIout     = 1'b1;
               HIin       = 1'b1;
               instr_done = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALTED: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase

      // The instruction's last state chains straight into the next fetch.
      if (instr_done && state_d != S_HALTED) state_d = run ? S_T0 : S_IDLE;
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         assert ($onehot0({PCout, MDRout, ZLOout, ZHIout, gp_out_en}));
      end
   end

endmodule
